// File: rtl/rvv_pkg.sv
// Shared RVV types for the vector front-end: encodings, decoded issue request
// and the EEW decode helper used by both load and store paths.
package rvv_pkg;

    localparam int unsigned VLEN     = 256;
    localparam int unsigned VlenB    = VLEN / 8;
    localparam int unsigned VrfDataW = 64;
    localparam int unsigned VlW      = $clog2(VlenB + 1);

    typedef logic [VrfDataW-1:0] vrf_data_t;
    typedef logic [VlW-1:0]      vl_t;
    typedef logic [VlW-1:0]      vlb_t;
    typedef logic [3:0]          insn_id_t;

    typedef enum logic [1:0] {
        EW8  = 2'd0,
        EW16 = 2'd1,
        EW32 = 2'd2,
        EW64 = 2'd3
    } vew_e;

    typedef enum logic [3:0] {
        VADD   = 4'd0,
        VSUB   = 4'd1,
        VSLL   = 4'd2,
        VSRL   = 4'd3,
        VSRA   = 4'd4,
        VMERGE = 4'd5,
        VLE    = 4'd6,
        VSE    = 4'd7
    } vop_e;

    localparam logic [6:0] OpcodeVec     = 7'b1010111;
    localparam logic [6:0] OpcodeLoadFP  = 7'b0000111;
    localparam logic [6:0] OpcodeStoreFP = 7'b0100111;

    localparam logic [2:0] OPIVV = 3'b000;
    localparam logic [2:0] OPIVI = 3'b011;
    localparam logic [2:0] OPIVX = 3'b100;

    localparam logic [5:0] Func6Vadd   = 6'b000000;
    localparam logic [5:0] Func6Vsub   = 6'b000010;
    localparam logic [5:0] Func6Vsll   = 6'b100101;
    localparam logic [5:0] Func6Vsrl   = 6'b101000;
    localparam logic [5:0] Func6Vsra   = 6'b101001;
    localparam logic [5:0] Func6Vmerge = 6'b010111;

    typedef struct packed {
        vew_e vsew;
        vl_t  vle;
    } vec_context_t;

    typedef struct packed {
        logic [5:0] func6;
        logic       vm;
        logic [4:0] vs2;
        logic [4:0] vs1;
        logic [2:0] func3;
        logic [4:0] vd;
        logic [6:0] opcode;
    } varith_type_t;

    typedef struct packed {
        logic [2:0] nf;
        logic       mew;
        logic [1:0] mop;
        logic       vm;
        logic [4:0] lumop;
        logic [4:0] rs1;
        logic [2:0] width;
        logic [4:0] vs3;
        logic [6:0] opcode;
    } vmem_type_t;

    typedef struct packed {
        insn_id_t   id;
        vop_e       vop;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
        logic [1:0] use_vs;
        logic       use_vd;
        logic       use_vm;
        vrf_data_t  scalar_op;
        vew_e       vew;
        vlb_t       vlb;
        logic       flip_bit;
    } issue_req_t;

    typedef struct packed {
        logic legal;
        vew_e eew;
    } eew_dec_t;

    function automatic eew_dec_t decode_eew(input logic [3:0] mew_width);
        eew_dec_t r;
        r.legal = 1'b1;
        case (mew_width)
            4'b0000: r.eew = EW8;
            4'b0101: r.eew = EW16;
            4'b0110: r.eew = EW32;
            4'b0111: r.eew = EW64;
            default: begin
                r.legal = 1'b0;
                r.eew   = EW8;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vinsn_decode_queue_decode.sv
// Purely combinational RVV decoder: raw instruction plus context and rs1
// into an issue request and an illegal flag.
module vinsn_decode_comb
    import rvv_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     insn_i,
    input  insn_id_t        insn_id_i,
    input  vec_context_t    vec_context_i,
    input  logic [XLEN-1:0] rs1_value_i,
    input  logic            flip_bit_i,
    output issue_req_t      req_o,
    output logic            illegal_o
);

    varith_type_t                arith_s;
    vmem_type_t                  mem_s;
    eew_dec_t                    eew_s;
    logic [VrfDataW+XLEN-1:0]    rs1_ext_s;
    logic                        unused_s;

    assign arith_s   = varith_type_t'(insn_i);
    assign mem_s     = vmem_type_t'(insn_i);
    assign eew_s     = decode_eew({mem_s.mew, mem_s.width});
    // Zero-pad first, then take the low part: covers XLEN both above and below the VRF width.
    assign rs1_ext_s = {{VrfDataW{1'b0}}, rs1_value_i};
    assign unused_s  = ^{mem_s.nf, mem_s.lumop, mem_s.rs1, mem_s.opcode,
                         rs1_ext_s[VrfDataW+XLEN-1:VrfDataW]};

    // Field extraction and legality check for arithmetic and unit-stride memory ops.
    always_comb begin
        req_o          = '0;
        req_o.id       = insn_id_i;
        req_o.flip_bit = flip_bit_i;
        illegal_o      = 1'b0;
        case (arith_s.opcode)
            OpcodeVec: begin
                req_o.vd     = arith_s.vd;
                req_o.vs1    = arith_s.vs1;
                req_o.vs2    = arith_s.vs2;
                req_o.use_vd = 1'b1;
                req_o.vew    = vec_context_i.vsew;
                req_o.vlb    = vlb_t'(vec_context_i.vle << vec_context_i.vsew);
                req_o.use_vm = ~arith_s.vm;
                case (arith_s.func3)
                    OPIVV: req_o.use_vs = 2'b11;
                    OPIVI: begin
                        req_o.use_vs    = 2'b10;
                        req_o.scalar_op = {{(VrfDataW-5){arith_s.vs1[4]}}, arith_s.vs1};
                    end
                    OPIVX: begin
                        req_o.use_vs    = 2'b10;
                        req_o.scalar_op = rs1_ext_s[VrfDataW-1:0];
                    end
                    default: illegal_o = 1'b1;
                endcase
                case (arith_s.func6)
                    Func6Vadd: req_o.vop = VADD;
                    Func6Vsub: req_o.vop = VSUB;
                    Func6Vsll: req_o.vop = VSLL;
                    Func6Vsrl: req_o.vop = VSRL;
                    Func6Vsra: req_o.vop = VSRA;
                    Func6Vmerge: begin
                        // vm=1 is the vmv.v.* form and ignores v0.
                        req_o.vop       = VMERGE;
                        req_o.use_vs[1] = 1'b1;
                        req_o.use_vm    = ~arith_s.vm;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            OpcodeLoadFP, OpcodeStoreFP: begin
                req_o.vew = eew_s.eew;
                req_o.vlb = vlb_t'(vec_context_i.vle << eew_s.eew);
                if (!eew_s.legal || (mem_s.mop != 2'b00) || !mem_s.vm) begin
                    illegal_o = 1'b1;
                end else begin
                    illegal_o = 1'b0;
                end
                if (arith_s.opcode == OpcodeStoreFP) begin
                    req_o.vs1    = mem_s.vs3;
                    req_o.use_vs = 2'b01;
                    req_o.use_vd = 1'b0;
                    req_o.vop    = VSE;
                end else begin
                    req_o.vd     = mem_s.vs3;
                    req_o.use_vs = 2'b00;
                    req_o.use_vd = 1'b1;
                    req_o.vop    = VLE;
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/vinsn_decode_queue_queue.sv
// FIFO of decoded issue requests with flush; pointers wrap by explicit compare
// so any depth works.
module vinsn_queue
    import rvv_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       push_i,
    input  issue_req_t data_i,
    input  logic       pop_i,
    output issue_req_t data_o,
    output logic       valid_o,
    output logic       full_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push_s, do_pop_s;
    issue_req_t      mem_q [Depth];

    assign valid_o   = (count_q != {CntW{1'b0}});
    assign full_o    = (count_q == CntW'(Depth));
    assign do_push_s = push_i && !full_o && !flush_i;
    assign do_pop_s  = pop_i && valid_o && !flush_i;
    assign data_o    = mem_q[rd_ptr_q];

    // Next pointers and occupancy; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {PtrW{1'b0}};
            rd_ptr_d = {PtrW{1'b0}};
            count_d  = {CntW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? {PtrW{1'b0}} : wr_ptr_q + PtrW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? {PtrW{1'b0}} : rd_ptr_q + PtrW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PtrW{1'b0}};
            rd_ptr_q <= {PtrW{1'b0}};
            count_q  <= {CntW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/vinsn_decode_queue.sv
// Vector instruction decoder with a decoded-request queue in front of the
// launcher; vl==0 instructions retire through the skip port.
module vinsn_decode_queue
    import rvv_pkg::*;
#(
    parameter int unsigned QueueDepth = 4,
    parameter int unsigned XLEN       = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     insn_i,
    input  insn_id_t        insn_id_i,
    input  vec_context_t    vec_context_i,
    input  logic [XLEN-1:0] rs1_value_i,
    input  logic            flush_i,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output issue_req_t      issue_req_o,
    output logic            illegal_insn_o,
    output logic            skip_valid_o,
    output insn_id_t        skip_id_o
);

    issue_req_t dec_req_s;
    logic       dec_illegal_s;
    logic       full_s;
    logic       accept_s, push_s, skip_s;
    logic       flip_bit_q, flip_bit_d;
    logic       skip_valid_q, skip_valid_d;
    insn_id_t   skip_id_q, skip_id_d;

    vinsn_decode_comb #(
        .XLEN(XLEN)
    ) u_decode (
        .insn_i       (insn_i),
        .insn_id_i    (insn_id_i),
        .vec_context_i(vec_context_i),
        .rs1_value_i  (rs1_value_i),
        .flip_bit_i   (flip_bit_q),
        .req_o        (dec_req_s),
        .illegal_o    (dec_illegal_s)
    );

    vinsn_queue #(
        .Depth(QueueDepth)
    ) u_queue (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .flush_i(flush_i),
        .push_i (push_s),
        .data_i (dec_req_s),
        .pop_i  (req_ready_i),
        .data_o (issue_req_o),
        .valid_o(req_valid_o),
        .full_o (full_s)
    );

    // ready_o must not look at req_ready_i, so a full queue never accepts.
    assign ready_o        = !full_s && !flush_i;
    assign accept_s       = valid_i && ready_o;
    assign illegal_insn_o = accept_s && dec_illegal_s;
    assign push_s         = accept_s && !dec_illegal_s && (vec_context_i.vle != '0);
    assign skip_s         = accept_s && !dec_illegal_s && (vec_context_i.vle == '0);

    // Flip bit and skip pulse next state.
    always_comb begin
        flip_bit_d   = flip_bit_q;
        skip_valid_d = skip_s;
        skip_id_d    = skip_id_q;
        if (push_s) begin
            flip_bit_d = ~flip_bit_q;
        end else begin
            flip_bit_d = flip_bit_q;
        end
        if (skip_s) begin
            skip_id_d = insn_id_i;
        end else begin
            skip_id_d = skip_id_q;
        end
    end

    // Flip bit and skip port registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flip_bit_q   <= 1'b0;
            skip_valid_q <= 1'b0;
            skip_id_q    <= '0;
        end else begin
            flip_bit_q   <= flip_bit_d;
            skip_valid_q <= skip_valid_d;
            skip_id_q    <= skip_id_d;
        end
    end

    assign skip_valid_o = skip_valid_q;
    assign skip_id_o    = skip_id_q;

endmodule

// File: doc/vinsn_decode_queue.md
# vinsn_decode_queue

Parametrised successor of the vector instruction decoder. It decodes RVV arithmetic (OPIVV/OPIVX/OPIVI, masked or unmasked) and unit-stride load/store instructions into `issue_req_t`, and buffers them in a `QueueDepth`-entry FIFO so the scalar core can run ahead of `vinsn_launcher`. Instructions with `vl == 0` retire immediately without being queued. A flush port lets the scalar core squash all buffered requests.

## Interface
- `QueueDepth`, 4, number of decoded-request entries; must be ≥ 2.
- `XLEN`, 64, width of the scalar operand `rs1_value_i`.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `valid_i` input 1: scalar core offers an instruction.
- `ready_o` output 1: decoder accepts the instruction; equals `!full && !flush_i`.
- `insn_i` input 32: raw instruction.
- `insn_id_i` input `insn_id_t`: scalar-core tag.
- `vec_context_i` input `vec_context_t`: vtype/vl at the time of issue.
- `rs1_value_i` input `XLEN`: scalar x[rs1], used by OPIVX.
- `flush_i` input 1: drop all queued requests.
- `req_valid_o` output 1: queue head valid.
- `req_ready_i` input 1: launcher consumes the head.
- `issue_req_o` output `issue_req_t`: queue head.
- `illegal_insn_o` output 1: same-cycle illegal flag, `valid_i && ready_o && illegal`.
- `skip_valid_o` output 1: one-cycle pulse for an accepted legal instruction with `vl == 0`.
- `skip_id_o` output `insn_id_t`: id for `skip_valid_o`.

## Operation
- **Accept.** An instruction is accepted when `valid_i && ready_o`.
  - Illegal instruction: flagged on `illegal_insn_o`, never enqueued.
  - Legal instruction with `vec_context_i.vle == 0`: produces a skip pulse and is not enqueued.
  - Any other legal instruction: pushed to the queue.
- **OpcodeVec**
  - `vd`, `vs1`, `vs2` and `use_vd = 1` are taken from the instruction.
  - `vlB = vle << vsew`, computed at `vlB` width with the overflow truncated.
  - `vew = vsew`.
  - `use_vm = !vm`; masked ops are now legal.
- **func3 decoding**
  - OPIVV: `use_vs = 2'b11`.
  - OPIVI: `use_vs = 2'b10`; `scalar_op` = the 5-bit imm sign-extended.
  - OPIVX: `use_vs = 2'b10`; `scalar_op` = `rs1_value_i` zero-padded or truncated to `vrf_data_t`.
  - Any other func3 is illegal.
- **func6 decoding**
  - VADD, VSUB, VSLL, VSRL, VSRA are legal.
  - VMERGE is legal in all three forms; `use_vs[1] = 1`, `use_vm = 1`. VMERGE with `vm = 1` (vmv.v.*) clears `use_vm`.
  - Any other func6 is illegal.
- **Load/store (OpcodeLoadFP / OpcodeStoreFP)**
  - EEW comes from `{mew, width}`: 0000→EW8, 0101→EW16, 0110→EW32, 0111→EW64. Anything else is illegal.
  - `mop != 0` is illegal, and so is `vm == 0`.
  - `vlB = vle << eew`; `vew = eew`.
  - Store: `vs1 = vs3`, `use_vs = 01`, `use_vd = 0`, `vop = VSE`.
  - Load: `vd = vs3`, `use_vs = 00`, `use_vd = 1`, `vop = VLE`.
- **Any other opcode** is illegal.
- **Flip bit.** `flip_bit_q` toggles on every push, and the pushed entry carries the pre-toggle value. Skips and illegals do not toggle it, and neither does flush.
- **Queue behaviour**
  - Pop when `req_valid_o && req_ready_i`.
  - Push and pop in the same cycle leave the count unchanged.
  - Full means `count == QueueDepth`. There is no push-through-pop when full, because `ready_o` must not depend on `req_ready_i`.
- **Flush**
  - With `flush_i = 1`, `ready_o = 0` and pops are ignored.
  - Next cycle: count = 0, `req_valid_o = 0`, and read/write pointers are reset to 0.

## Timing
- **Reset values:** `req_valid_o = 0`, `ready_o = 1`, `illegal_insn_o = 0`, `skip_valid_o = 0`, count = 0, pointers = 0, flip = 0. Queue storage is not reset.
- **Latency:** accept at cycle N → `req_valid_o` at N+1 when the queue was empty. There is no combinational input→`issue_req_o` path.
- **Throughput:** 1 instruction/cycle sustained when the launcher is ready every cycle.
- **`skip_valid_o`/`skip_id_o`:** registered, high exactly in cycle N+1 for an accept at N.
- **`illegal_insn_o`:** combinational in cycle N; nothing else changes.
- **Pointer wrap:** pointers wrap modulo `QueueDepth`, including non-power-of-2 depths, using an explicit compare to `QueueDepth-1`.
- **`issue_req_o`** holds stable while `req_valid_o && !req_ready_i`.
- **Reset mid-operation:** the queue empties immediately, because the reset is asynchronous.

## Structure
- **Additions to `rvv_pkg`:**
  - `use_vm` bit in `issue_req_t`.
  - OPIVX func3 constant.
  - `mop` field in `vmem_type_t`.
  - `decode_eew` function shared by the load and store paths.
- **Sub-modules:**
  - `vinsn_decode_comb`: purely combinational; `insn` + context + rs1 → `{issue_req_t, illegal}`.
  - `vinsn_queue`: FIFO of `issue_req_t` with count, wrap, flush and `QueueDepth` parameter.

## Test plan
- **Back-to-back pushes until full:** 5 × vadd.vv with `QueueDepth = 4`, `req_ready_i = 0`.
  - `ready_o` falls after the 4th accept.
  - Flip bits are 0, 1, 0, 1.
  - `req_valid_o` first rises at N+1.
- **OPIVX:** vadd.vx with `rs1_value_i = 64'hFFFF_FFFF_0000_0005`, vsew = EW32, vl = 8 → `scalar_op` low bits = `...0005`, `use_vs = 10`, `vlB = 32`.
- **Masked vadd.vi** with imm = 5'b10000 → `use_vm = 1`, `scalar_op` = -16 sign-extended, `illegal_insn_o = 0`.
- **vl = 0 vle32** with id 7 → `skip_valid_o = 1`, `skip_id_o = 7` at N+1, queue count unchanged, flip bit unchanged.
- **Illegal encodings:** `{mew,width} = 4'b1000` store, and func6 = vmul.
  - `illegal_insn_o = 1` in the same cycle; no push.
  - A following legal instruction gets the un-toggled flip bit.
- **Flush:** 3 entries queued, then `flush_i` in the same cycle as `req_ready_i` and `valid_i` → no pop, no accept, `req_valid_o = 0` next cycle, next push lands at slot 0.
